// File: rtl/turbo_pkg.sv
// Constants shared by the 7-symbol turbo interleaver and deinterleaver.
// Tables give, for each output slot, the arrival index it is read from.
package turbo_pkg;

  localparam int FRAME_LEN = 7;
  localparam int CNT_W     = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEINT_SRC [FRAME_LEN] = '{3'd0, 3'd3, 3'd5, 3'd2, 3'd4, 3'd6, 3'd1};
  localparam cnt_t INT_SRC   [FRAME_LEN] = '{3'd0, 3'd6, 3'd3, 3'd1, 3'd4, 3'd2, 3'd5};

  function automatic cnt_t deint_src(input cnt_t j);
    cnt_t src;
    src = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (j == cnt_t'(i)) src = DEINT_SRC[i];
    end
    return src;
  endfunction

endpackage

// File: rtl/pingpong_frame_buf.sv
// Two-bank frame store with per-bank full flags; write into the bank being filled while the other drains.
// Reads are combinational from registered state; the writer stalls whenever its target bank is still full.
module pingpong_frame_buf
  import turbo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_en,
  input  cnt_t         i_wr_addr,
  input  logic [W-1:0] i_wr_dat,
  input  logic         i_wr_commit,
  input  cnt_t         i_rd_addr,
  input  logic         i_rd_release,
  output logic         o_wr_full,
  output logic         o_rd_full,
  output logic [W-1:0] o_rd_dat
);

  logic [W-1:0] r_mem [2][FRAME_LEN];
  logic [1:0]   r_full;
  logic         r_wbank;
  logic         r_rbank;

  // Commit and release always address different banks: commit targets a
  // non-full bank, release a full one, so both updates can land together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full  <= '0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
    end else begin
      if (i_wr_commit) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank         <= ~r_wbank;
      end
      if (i_rd_release) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wbank][i_wr_addr] <= i_wr_dat;
  end

  assign o_wr_full = r_full[r_wbank];
  assign o_rd_full = r_full[r_rbank];
  assign o_rd_dat  = r_mem[r_rbank][i_rd_addr];

endmodule

// File: rtl/turbo_deinterleaver.sv
// Streaming 7-symbol turbo deinterleaver over a ping-pong buffer: first output the cycle after the 7th accept,
// 1 symbol/cycle sustained; in_ready_o drops only while both banks hold unread frames.
module turbo_deinterleaver
  import turbo_pkg::*;
#(
  parameter int W = 8,
  parameter int N = FRAME_LEN
) (
  input  logic         clk_p_i,
  input  logic         reset_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  output logic         frame_err_o
);

  localparam cnt_t LAST = cnt_t'(N - 1);

  cnt_t         r_wcnt;
  cnt_t         r_rcnt;
  logic         r_frame_err;
  logic         w_wr_full;
  logic         w_rd_full;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_wr_last;
  logic         w_rd_last;
  logic         w_commit;
  logic         w_release;
  logic [W-1:0] w_rd_dat;

  assign w_in_fire  = in_valid_i && !w_wr_full;
  assign w_wr_last  = (r_wcnt == LAST);
  assign w_rd_last  = (r_rcnt == LAST);
  assign w_out_fire = w_rd_full && out_ready_i;
  // Only a frame whose in_last_i lines up with slot 6 becomes readable.
  assign w_commit   = w_in_fire && w_wr_last && in_last_i;
  assign w_release  = w_out_fire && w_rd_last;

  assign in_ready_o  = !w_wr_full;
  assign out_valid_o = w_rd_full;
  assign out_data_o  = w_rd_dat;
  assign out_last_o  = w_rd_full && w_rd_last;
  assign frame_err_o = r_frame_err;

  always_ff @(posedge clk_p_i) begin
    if (reset_i) begin
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_in_fire && (in_last_i != w_wr_last);
      // An early in_last_i also restarts the frame, discarding the partial one.
      if (w_in_fire) r_wcnt <= (w_wr_last || in_last_i) ? '0 : r_wcnt + cnt_t'(1);
      if (w_out_fire) r_rcnt <= w_rd_last ? '0 : r_rcnt + cnt_t'(1);
    end
  end

  pingpong_frame_buf #(
    .W(W)
  ) u_buf (
    .i_clk       (clk_p_i),
    .i_rst       (reset_i),
    .i_wr_en     (w_in_fire),
    .i_wr_addr   (r_wcnt),
    .i_wr_dat    (in_data_i),
    .i_wr_commit (w_commit),
    .i_rd_addr   (deint_src(r_rcnt)),
    .i_rd_release(w_release),
    .o_wr_full   (w_wr_full),
    .o_rd_full   (w_rd_full),
    .o_rd_dat    (w_rd_dat)
  );

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Directed bench for turbo_deinterleaver: reorder, round trip, backpressure, back-to-back, framing errors, reset.
module tb_turbo_deinterleaver;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic       in_last_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       frame_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_err    = 0;
  logic [7:0] oq [$];
  logic       lq [$];

  localparam int DSRC [7] = '{0, 3, 5, 2, 4, 6, 1};
  localparam int ISRC [7] = '{0, 6, 3, 1, 4, 2, 5};
  localparam logic [7:0] BASIC_EXP [7] = '{8'h10, 8'h13, 8'h15, 8'h12, 8'h14, 8'h16, 8'h11};
  localparam logic [7:0] GOOD_EXP  [7] = '{8'h20, 8'h23, 8'h25, 8'h22, 8'h24, 8'h26, 8'h21};

  always #5 clk = ~clk;

  turbo_deinterleaver #(.W(8), .N(7)) dut (
    .clk_p_i    (clk),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .frame_err_o(frame_err_o)
  );

  // Inputs change only at #1 after posedge, so at negedge they show what the next edge transfers.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (out_valid_o && out_ready_i) begin
        oq.push_back(out_data_o);
        lq.push_back(out_last_o);
      end
      if (in_valid_i && in_ready_o) n_acc++;
      if (frame_err_o) n_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    oq.delete();
    lq.delete();
    n_acc = 0;
    n_err = 0;
  endtask

  function automatic logic [7:0] get_o(input int idx);
    return (idx < oq.size()) ? oq[idx] : 8'hxx;
  endfunction

  function automatic logic get_l(input int idx);
    return (idx < lq.size()) ? lq[idx] : 1'bx;
  endfunction

  task automatic push(input logic [7:0] d, input logic l, input int budget, output bit ok);
    ok = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    for (int c = 0; c < budget && !ok; c++) begin
      ok = in_ready_o;
      step(1);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    in_valid_i = 1'b0; in_data_i = 8'h00; in_last_i = 1'b0; out_ready_i = 1'b0; reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    n_checks++; if (out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last_o); end
    n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_basic_reorder();
    bit ok;
    int bad = 0;
    clear_mon();
    out_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early got=%b exp=0", out_valid_o); end
      end
      push(8'(16 + k), k == 6, 4, ok);
      if (!ok) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_accepts stalled=%0d exp=0", bad); end
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10) begin
      n_fail++; $display("FAIL basic_first_out valid=%b data=%h exp valid=1 data=10", out_valid_o, out_data_o);
    end
    step(7);
    n_checks++; if (oq.size() != 7) begin n_fail++; $display("FAIL basic_count got=%0d exp=7", oq.size()); end
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (get_o(j) !== BASIC_EXP[j] || get_l(j) !== (j == 6)) begin
        n_fail++; $display("FAIL basic_out[%0d] got=%h last=%b exp=%h last=%b", j, get_o(j), get_l(j), BASIC_EXP[j], j == 6);
      end
    end
  endtask

  task automatic test_round_trip();
    bit ok;
    int bad = 0;
    logic [6:0] vv;
    logic [6:0] rec;
    logic [7:0] got;
    clear_mon();
    out_ready_i = 1'b1;
    for (int v = 0; v < 128; v++) begin
      vv = 7'(v);
      for (int k = 0; k < 7; k++) begin
        push({7'b0, vv[ISRC[k]]}, k == 6, 4, ok);
        if (!ok) bad++;
      end
    end
    step(10);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rt_accepts stalled=%0d exp=0", bad); end
    n_checks++; if (oq.size() != 896) begin n_fail++; $display("FAIL rt_count got=%0d exp=896", oq.size()); end
    for (int v = 0; v < 128; v++) begin
      for (int j = 0; j < 7; j++) begin
        got = get_o(v * 7 + j);
        rec[j] = got[0];
      end
      n_checks++;
      if (rec !== 7'(v)) begin n_fail++; $display("FAIL rt_vec got=%b exp=%b", rec, 7'(v)); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    int unstable = 0;
    logic [7:0] e;
    clear_mon();
    out_ready_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      push(8'(64 + (i / 7) * 8 + i % 7), (i % 7) == 6, 4, ok);
      if (!ok) bad++;
    end
    n_checks++; if (n_acc != 14 || bad != 0) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=14", n_acc); end
    push(8'h50, 1'b0, 5, ok);
    n_checks++; if (ok !== 1'b0 || in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall accepted=%b in_ready=%b exp 0/0", ok, in_ready_o);
    end
    for (int c = 0; c < 4; c++) begin
      if (out_valid_o !== 1'b1 || out_data_o !== 8'h40) unstable++;
      step(1);
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", unstable); end
    out_ready_i = 1'b1;
    bad = 0;
    for (int i = 14; i < 21; i++) begin
      push(8'(64 + (i / 7) * 8 + i % 7), (i % 7) == 6, 20, ok);
      if (!ok) bad++;
    end
    step(25);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_resume stalled=%0d exp=0", bad); end
    n_checks++; if (oq.size() != 21) begin n_fail++; $display("FAIL bp_count got=%0d exp=21", oq.size()); end
    for (int i = 0; i < 21; i++) begin
      e = 8'(64 + (i / 7) * 8 + DSRC[i % 7]);
      n_checks++;
      if (get_o(i) !== e) begin n_fail++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, get_o(i), e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad = 0;
    int dbad = 0;
    int lbad = 0;
    clear_mon();
    out_ready_i = 1'b1;
    for (int i = 0; i < 70; i++) begin
      push(8'((i / 7) * 16 + i % 7), (i % 7) == 6, 1, ok);
      if (!ok) bad++;
    end
    step(7);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_in_bubbles got=%0d exp=0", bad); end
    n_checks++; if (oq.size() != 70) begin n_fail++; $display("FAIL b2b_out_count got=%0d exp=70", oq.size()); end
    for (int i = 0; i < 70; i++) begin
      if (get_o(i) !== 8'((i / 7) * 16 + DSRC[i % 7])) dbad++;
      if (get_l(i) !== ((i % 7) == 6)) lbad++;
    end
    n_checks++; if (dbad != 0) begin n_fail++; $display("FAIL b2b_data wrong=%0d exp=0", dbad); end
    n_checks++; if (lbad != 0) begin n_fail++; $display("FAIL b2b_last wrong=%0d exp=0", lbad); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_frame_err();
    bit ok;
    clear_mon();
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) push(8'(48 + k), k == 3, 4, ok);
    n_checks++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL err_early_pulse got=%b exp=1", frame_err_o); end
    step(1);
    n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL err_early_width got=%b exp=0", frame_err_o); end
    for (int k = 0; k < 7; k++) push(8'(32 + k), k == 6, 4, ok);
    step(8);
    n_checks++; if (n_err != 1) begin n_fail++; $display("FAIL err_early_count got=%0d exp=1", n_err); end
    n_checks++; if (oq.size() != 7) begin n_fail++; $display("FAIL err_early_outs got=%0d exp=7", oq.size()); end
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (get_o(j) !== GOOD_EXP[j]) begin n_fail++; $display("FAIL err_early_out[%0d] got=%h exp=%h", j, get_o(j), GOOD_EXP[j]); end
    end
    // Seven symbols with no in_last_i: the 7th is flagged and the whole frame vanishes.
    for (int k = 0; k < 7; k++) push(8'(112 + k), 1'b0, 4, ok);
    n_checks++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL err_late_pulse got=%b exp=1", frame_err_o); end
    step(3);
    n_checks++; if (oq.size() != 7 || n_err != 2) begin
      n_fail++; $display("FAIL err_late_drop outs=%0d errs=%0d exp 7/2", oq.size(), n_err);
    end
    for (int k = 0; k < 7; k++) push(8'(32 + k), k == 6, 4, ok);
    step(8);
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (get_o(7 + j) !== GOOD_EXP[j]) begin n_fail++; $display("FAIL err_late_out[%0d] got=%h exp=%h", j, get_o(7 + j), GOOD_EXP[j]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    out_ready_i = 1'b0;
    for (int i = 0; i < 14; i++) push(8'(80 + (i / 7) * 8 + i % 7), (i % 7) == 6, 4, ok);
    out_ready_i = 1'b1;
    step(3);
    out_ready_i = 1'b0;
    n_checks++; if (get_o(0) !== 8'h50 || get_o(1) !== 8'h53 || get_o(2) !== 8'h55 || oq.size() != 3) begin
      n_fail++; $display("FAIL rst_pre_outs got=%h %h %h n=%0d exp=50 53 55 n=3", get_o(0), get_o(1), get_o(2), oq.size());
    end
    reset_i = 1'b1;
    step(1);
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state valid=%b ready=%b exp 0/1", out_valid_o, in_ready_o);
    end
    reset_i = 1'b0;
    clear_mon();
    out_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) push(8'(96 + k), k == 6, 4, ok);
    step(8);
    n_checks++; if (oq.size() != 7) begin n_fail++; $display("FAIL rst_fresh_count got=%0d exp=7", oq.size()); end
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (get_o(j) !== 8'(96 + DSRC[j])) begin n_fail++; $display("FAIL rst_fresh_out[%0d] got=%h exp=%h", j, get_o(j), 8'(96 + DSRC[j])); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_reorder();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
